// File: rtl/div_unit_pkg.sv
// Shared types for the integer divider.
//
// Package common : ALU function codes seen by the divider, the machine word type
//                  and a plain 64-bit alias.
// Package pipes  : divider FSM state encoding and the iteration count for a full
//                  64-bit divide.
//
// Optional feature macro used by div_unit: DIV_FAST_SPECIAL_EN.

package common;

   localparam int XLEN = 64;

   typedef logic [XLEN-1:0] word_t;
   typedef logic [63:0]     u64;

   // Only the divide-class functions reach the divider.
   typedef enum logic [1:0] {
      ALU_DIV  = 2'd0,
      ALU_DIVU = 2'd1,
      ALU_REM  = 2'd2,
      ALU_REMU = 2'd3
   } alufunc_t;

endpackage

package pipes;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_t;

   localparam int DIV_ITERS = 64;

endpackage

// File: rtl/div_unit_step.sv
// One radix-2 restoring division step (purely combinational).
//
// Ports:
//   rem_in  : partial remainder entering this step
//   q_in    : dividend/quotient shift register; its MSB is the next dividend bit
//   d       : divisor magnitude
//   rem_out : partial remainder after the conditional subtract
//   q_out   : q_in shifted left with the new quotient bit in the LSB

module div_step #(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic [WIDTH-1:0] q_in,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] rem_out,
   output logic [WIDTH-1:0] q_out
);

   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] diff;
   logic             ge;

   // The shifted remainder needs one extra bit for the compare. When the
   // subtract is taken the true difference is below d, so the low WIDTH bits
   // of a WIDTH-bit subtract are exact.
   always_comb begin
      shifted = {rem_in, q_in[WIDTH-1]};
      ge      = (shifted >= {1'b0, d});
      diff    = shifted[WIDTH-1:0] - d;
      rem_out = ge ? diff : shifted[WIDTH-1:0];
      q_out   = {q_in[WIDTH-2:0], ge};
   end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU and their W forms.
// Operands arrive already sign/zero-extended by decode. The unit holds busy
// while computing and presents its result with a one-cycle out_valid pulse.
//
// Ports:
//   clk       : pipeline clock
//   reset     : asynchronous, active-low; clears all state
//   in_valid  : start request, only looked at in IDLE
//   alufunc   : ALU_DIV / ALU_DIVU / ALU_REM / ALU_REMU
//   is_word   : W form; result is sign-extended from bit 31
//   rd1, rd2  : dividend, divisor
//   flush     : abort the in-flight operation
//   busy      : high from the accept edge until the end of the done cycle
//   out_valid : one-cycle pulse, result valid in that cycle
//   result    : quotient or remainder, held until a later operation completes
//
// Optional feature macro DIV_FAST_SPECIAL_EN: when defined, divide-by-zero and
// signed overflow skip the iterations and complete in the cycle after accept.
// When undefined every operation takes the full iteration count; results are
// identical either way.

module div_unit
   import common::*;
   import pipes::*;
#(
   parameter int WIDTH = DIV_ITERS,
   parameter int CNT_W = 7
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  alufunc_t         alufunc,
   input  logic             is_word,
   input  logic [WIDTH-1:0] rd1,
   input  logic [WIDTH-1:0] rd2,
   input  logic             flush,
   output logic             busy,
   output logic             out_valid,
   output logic [WIDTH-1:0] result
);

   localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH-1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   div_state_t       state_q,    state_d;
   logic [CNT_W-1:0] cnt_q,      cnt_d;
   logic [WIDTH-1:0] q_q,        q_d;
   logic [WIDTH-1:0] rem_q,      rem_d;
   logic [WIDTH-1:0] dsr_q,      dsr_d;
   logic [WIDTH-1:0] dvd_raw_q,  dvd_raw_d;
   logic             neg_quo_q,  neg_quo_d;
   logic             neg_rem_q,  neg_rem_d;
   logic             div0_q,     div0_d;
   logic             ovf_q,      ovf_d;
   logic             want_rem_q, want_rem_d;
   logic             word_op_q,  word_op_d;
   logic [WIDTH-1:0] res_new_q,  res_new_d;
   logic [WIDTH-1:0] result_q,   result_d;

   logic             op_signed;
   logic             op_rem;
   logic [WIDTH-1:0] rd1_mag;
   logic [WIDTH-1:0] rd2_mag;
   logic             div0_in;
   logic             ovf_in;
   logic             accept;
   logic [WIDTH-1:0] step_rem;
   logic [WIDTH-1:0] step_q;

   function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
      return (~v) + ONE;
   endfunction

   // Special-case flags override the iterated magnitudes, so the fast path
   // can call this with zero magnitudes and still get the right answer.
   function automatic logic [WIDTH-1:0] pick_result(
      input logic [WIDTH-1:0] quo_mag,
      input logic [WIDTH-1:0] rem_mag,
      input logic [WIDTH-1:0] dividend,
      input logic             div0,
      input logic             ovf,
      input logic             neg_quo,
      input logic             neg_rem,
      input logic             want_rem,
      input logic             word_op
   );
      logic [WIDTH-1:0] quo;
      logic [WIDTH-1:0] rmd;
      logic [WIDTH-1:0] r;
      if (div0) begin
         quo = '1;
         rmd = dividend;
      end else if (ovf) begin
         quo = dividend;
         rmd = '0;
      end else begin
         quo = neg_quo ? negate(quo_mag) : quo_mag;
         rmd = neg_rem ? negate(rem_mag) : rem_mag;
      end
      r = want_rem ? rmd : quo;
      if (word_op) begin
         r = {{(WIDTH-32){r[31]}}, r[31:0]};
      end
      return r;
   endfunction

   // Operand decode at the accept edge: magnitudes for signed ops, and the
   // two special cases that bypass the iterated answer.
   always_comb begin
      op_signed = (alufunc == ALU_DIV) || (alufunc == ALU_REM);
      op_rem    = (alufunc == ALU_REM) || (alufunc == ALU_REMU);
      rd1_mag   = (op_signed && rd1[WIDTH-1]) ? negate(rd1) : rd1;
      rd2_mag   = (op_signed && rd2[WIDTH-1]) ? negate(rd2) : rd2;
      div0_in   = (rd2 == '0);
      ovf_in    = op_signed && (rd1 == MIN_NEG) && (rd2 == '1);
      accept    = (state_q == IDLE) && in_valid && !flush;
   end

   div_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .rem_in  (rem_q),
      .q_in    (q_q),
      .d       (dsr_q),
      .rem_out (step_rem),
      .q_out   (step_q)
   );

   // Next-state logic. The new result is captured on the edge that enters
   // DONE and only becomes the held result when DONE completes unflushed,
   // so a flushed operation never disturbs the last delivered value.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      q_d        = q_q;
      rem_d      = rem_q;
      dsr_d      = dsr_q;
      dvd_raw_d  = dvd_raw_q;
      neg_quo_d  = neg_quo_q;
      neg_rem_d  = neg_rem_q;
      div0_d     = div0_q;
      ovf_d      = ovf_q;
      want_rem_d = want_rem_q;
      word_op_d  = word_op_q;
      res_new_d  = res_new_q;
      result_d   = result_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               cnt_d      = '0;
               rem_d      = '0;
               q_d        = rd1_mag;
               dsr_d      = rd2_mag;
               dvd_raw_d  = rd1;
               neg_quo_d  = op_signed && (rd1[WIDTH-1] ^ rd2[WIDTH-1]);
               neg_rem_d  = op_signed && rd1[WIDTH-1];
               div0_d     = div0_in;
               ovf_d      = ovf_in;
               want_rem_d = op_rem;
               word_op_d  = is_word;
`ifdef DIV_FAST_SPECIAL_EN
               if (div0_in || ovf_in) begin
                  state_d   = DONE;
                  res_new_d = pick_result('0, '0, rd1, div0_in, ovf_in,
                                          1'b0, 1'b0, op_rem, is_word);
               end else begin
                  state_d = RUN;
               end
`else
               state_d = RUN;
`endif
            end
         end

         RUN: begin
            if (flush) begin
               state_d = IDLE;
            end else begin
               rem_d = step_rem;
               q_d   = step_q;
               cnt_d = cnt_q + CNT_ONE;
               if (cnt_q == CNT_LAST) begin
                  state_d   = DONE;
                  res_new_d = pick_result(step_q, step_rem, dvd_raw_q, div0_q, ovf_q,
                                          neg_quo_q, neg_rem_q, want_rem_q, word_op_q);
               end
            end
         end

         DONE: begin
            state_d = IDLE;
            if (!flush) begin
               result_d = res_new_q;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         q_q        <= '0;
         rem_q      <= '0;
         dsr_q      <= '0;
         dvd_raw_q  <= '0;
         neg_quo_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         div0_q     <= 1'b0;
         ovf_q      <= 1'b0;
         want_rem_q <= 1'b0;
         word_op_q  <= 1'b0;
         res_new_q  <= '0;
         result_q   <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         q_q        <= q_d;
         rem_q      <= rem_d;
         dsr_q      <= dsr_d;
         dvd_raw_q  <= dvd_raw_d;
         neg_quo_q  <= neg_quo_d;
         neg_rem_q  <= neg_rem_d;
         div0_q     <= div0_d;
         ovf_q      <= ovf_d;
         want_rem_q <= want_rem_d;
         word_op_q  <= word_op_d;
         res_new_q  <= res_new_d;
         result_q   <= result_d;
      end
   end

   // Outputs: the fresh result is shown only while it is being delivered.
   always_comb begin
      busy      = (state_q != IDLE);
      out_valid = (state_q == DONE) && !flush;
      result    = out_valid ? res_new_q : result_q;
   end

endmodule
